// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bus between a requesting master and serial_add_ctrl.
// SERIAL_ADD_SUB_EN adds the 'sub' request bit.
interface serial_add_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] SUM;
  logic         COUT;

  modport master (
    output start, A, B, cin,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  ready, busy, done, SUM, COUT
  );

  modport slave (
    input  start, A, B, cin,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output ready, busy, done, SUM, COUT
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder controller driving a 1-bit full-adder cell, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.

// Full-adder cell: y is the population count of the three inputs, y[1]=carry, y[0]=sum.
module fa_cell (
  input  logic [2:0] x,
  output logic [1:0] y
);
  assign y = {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
endmodule

module serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  opa_q, opa_d;
  logic [N-1:0]  opb_q, opb_d;
  logic [N-1:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic [1:0]    fa_y;
  logic [N-1:0]  b_load;
  logic          c_load;

  fa_cell u_fa (
    .x ({opa_q[0], opb_q[0], carry_q}),
    .y (fa_y)
  );

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as A + ~B + 1; cin is ignored in that mode.
  assign b_load = bus.sub ? ~bus.B : bus.B;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.B;
  assign c_load = bus.cin;
`endif

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opa_d   = bus.A;
          opb_d   = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = {fa_y[0], res_q[N-1:1]};
        carry_d = fa_y[1];
        opa_d   = {1'b0, opa_q[N-1:1]};
        opb_d   = {1'b0, opb_q[N-1:1]};
        cnt_d   = cnt_q + 1'b1;
        // Publish only the completed word so SUM never shows partial bits.
        if (cnt_q == LAST) begin
          sum_d   = {fa_y[0], res_q[N-1:1]};
          cout_d  = fa_y[1];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign bus.SUM   = sum_q;
  assign bus.COUT  = cout_q;
endmodule
